memory_fill_responder: RTL and testbench

MEMORY_FILL_RESPONDER -- requirements
Module: memory_fill_responder

---
 rtl/memory_fill_responder.sv | 115 +++++++++++
 tb/tb_memory_fill_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_fill_responder.sv
// 1024x16 word memory with a 4-cycle fully pipelined read path and synchronous writes.
// Define MEM_BURST_EN to enable 8-beat aligned burst reads (busy held until the last beat returns).
module memory_fill_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        burst,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy
);

  localparam int DEPTH  = 1024;
  localparam int STAGES = 4;

  logic [15:0]       mem [DEPTH];
  logic [15:0]       data_pipe_reg [STAGES];
  logic [STAGES-1:0] valid_pipe_reg;

  logic       accept;
  logic       wr_en;
  logic       rd_en;
  logic [9:0] req_index;
  logic [9:0] rd_index;
  logic       unused_bits;

  assign req_index   = addr[10:1];
  assign accept      = enable && !busy && !rst;
  assign wr_en       = accept && wr;
  assign unused_bits = ^{addr[15:11], addr[0], burst};

`ifdef MEM_BURST_EN
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [6:0] base_reg, base_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      base_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      base_reg  <= base_next;
    end
  end

  // cnt_reg equals cycles since the burst request: beats 1..7 issue, then 8..11 drain
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    base_next  = base_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept && !wr && burst) begin
          state_next = S_ISSUE;
          cnt_next   = 4'd1;
          base_next  = addr[10:4];
        end
      end
      S_ISSUE: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'd7) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'd11) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    busy     = (state_reg != S_IDLE);
    rd_en    = accept && !wr;
    rd_index = burst ? {addr[10:4], 3'd0} : req_index;
    if (state_reg == S_ISSUE) begin
      rd_en    = 1'b1;
      rd_index = {base_reg, cnt_reg[2:0]};
    end
  end
`else
  assign busy     = 1'b0;
  assign rd_en    = accept && !wr;
  assign rd_index = req_index;
`endif

  // Array is never reset; the read register doubles as pipeline stage 0.
  always_ff @(posedge clk) begin
    if (wr_en) mem[req_index] <= data_in;
    data_pipe_reg[0] <= mem[rd_index];
    for (int i = 1; i < STAGES; i++) data_pipe_reg[i] <= data_pipe_reg[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) valid_pipe_reg <= '0;
    else     valid_pipe_reg <= {valid_pipe_reg[STAGES-2:0], rd_en};
  end

  assign data_valid = valid_pipe_reg[STAGES-1];
  assign data_out   = data_valid ? data_pipe_reg[STAGES-1] : 16'h0000;

endmodule

// File: tb/tb_memory_fill_responder.sv
// Self-checking bench for memory_fill_responder: table-driven requests with a response scoreboard.
// Burst scenarios are compiled in when MEM_BURST_EN is defined.
module tb_memory_fill_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic        burst = 1'b0;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;

  memory_fill_responder dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .burst(burst), .data_out(data_out),
    .data_valid(data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    int          due;
  } resp_t;

  typedef struct {
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  resp_t sb[$];
  int    total = 0;
  int    bad = 0;
  int    busy_from = 1;
  int    busy_until = 0;
  bit    mon_on = 1'b0;

  function automatic logic exp_busy(input int c);
    return (c >= busy_from) && (c <= busy_until);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One request cycle; the expected response (if any) is queued here.
  task automatic drive(input logic en_i, input logic wr_i, input logic b_i,
                       input logic [15:0] a_i, input logic [15:0] d_i,
                       input logic [15:0] exp_i, input logic rs_i);
    resp_t e;
    enable  = en_i;
    wr      = wr_i;
    burst   = b_i;
    addr    = a_i;
    data_in = d_i;
    rst     = rs_i;
    if (rs_i) begin
      while (sb.size() != 0 && sb[$].due > cyc) void'(sb.pop_back());
      if (busy_until > cyc) busy_until = cyc;
    end else if (en_i && !wr_i && !exp_busy(cyc)) begin
`ifdef MEM_BURST_EN
      if (b_i) begin
        for (int k = 0; k < 8; k++) begin
          e.data = exp_i + 16'(k);
          e.due  = cyc + 4 + k;
          sb.push_back(e);
        end
        busy_from  = cyc + 1;
        busy_until = cyc + 11;
      end else begin
        e.data = exp_i;
        e.due  = cyc + 4;
        sb.push_back(e);
      end
`else
      e.data = exp_i;
      e.due  = cyc + 4;
      sb.push_back(e);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
  endtask

  always @(negedge clk) begin
    resp_t e;
    if (mon_on) begin
      check("busy", {31'd0, busy}, {31'd0, exp_busy(cyc)});
      if (data_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid actual=%h required=no_response (cycle %0d)", data_out, cyc);
        end else begin
          e = sb.pop_front();
          $display("resp cycle=%0d data=%h required=%h due=%0d", cyc, data_out, e.data, e.due);
          check("rd_data", {16'd0, data_out}, {16'd0, e.data});
          check("rd_cycle", cyc, e.due);
        end
      end else begin
        check("idle_data_out", {16'd0, data_out}, 32'd0);
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          total++;
          bad++;
          $display("FAIL missing_valid actual=none required=%h due=%0d (cycle %0d)", e.data, e.due, cyc);
        end
      end
    end
  end

  vec_t vecs[$];

  initial begin
    // Preload, write-then-read, back-to-back reads, read-before-write, alias, disabled write.
    vecs = '{
      '{1'b1, 1'b1, 16'h0000, 16'h0001, 16'h0000},
      '{1'b1, 1'b1, 16'h0002, 16'h0002, 16'h0000},
      '{1'b1, 1'b1, 16'h0004, 16'h0003, 16'h0000},
      '{1'b1, 1'b1, 16'h0006, 16'h0004, 16'h0000},
      '{1'b1, 1'b1, 16'h0020, 16'h7777, 16'h0000},
      '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000},
      '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF},
      '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000},
      '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0001},
      '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0002},
      '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h0003},
      '{1'b1, 1'b0, 16'h0006, 16'h0000, 16'h0004},
      '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h7777},
      '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000},
      '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234},
      '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0000},
      '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF},
      '{1'b1, 1'b1, 16'h0802, 16'h5555, 16'h0000},
      '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h5555},
      '{1'b1, 1'b0, 16'h0803, 16'h0000, 16'h5555},
      '{1'b1, 1'b0, 16'hF821, 16'h0000, 16'h1234}
    };

    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    check("reset_data_valid", {31'd0, data_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_data_out", {16'd0, data_out}, 32'd0);
    mon_on = 1'b1;

    foreach (vecs[i]) drive(vecs[i].en, vecs[i].wr, 1'b0, vecs[i].addr, vecs[i].data, vecs[i].exp, 1'b0);
    idle(6);

    // Reset with three reads in flight; the write presented alongside rst must be ignored.
    drive(1'b1, 1'b1, 1'b0, 16'h0060, 16'hCAFE, 16'h0, 1'b0);
    idle(2);
    drive(1'b1, 1'b0, 1'b0, 16'h0060, 16'h0, 16'hCAFE, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0, 16'h0001, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0, 16'h0003, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 16'h0060, 16'h0000, 16'h0, 1'b1);
    check("post_rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_data_out", {16'd0, data_out}, 32'd0);
    idle(6);
    drive(1'b1, 1'b0, 1'b0, 16'h0060, 16'h0, 16'hCAFE, 1'b0);
    idle(6);

`ifdef MEM_BURST_EN
    for (int k = 0; k < 8; k++)
      drive(1'b1, 1'b1, 1'b0, 16'h0040 + 16'(2 * k), 16'h00A0 + 16'(k), 16'h0, 1'b0);
    idle(4);
    // Two singles ahead of the burst, then a write and a read that must be dropped while busy.
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0, 16'h0001, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0, 16'h0003, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 16'h0046, 16'h0, 16'h00A0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 16'h0040, 16'hFFFF, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0002, 16'h0, 16'h5555, 1'b0);
    idle(12);
    drive(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0, 16'h00A0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h004E, 16'h0, 16'h00A7, 1'b0);
    idle(6);
`else
    // Without burst support a burst read is an ordinary single read.
    drive(1'b1, 1'b0, 1'b1, 16'h0006, 16'h0, 16'h0004, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0, 16'hBEEF, 1'b0);
    idle(6);
`endif

    idle(4);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
